// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state, default geometry and address-field width helpers
package icache_pkg;
   typedef enum logic [1:0] {IDLE, REFILL, BYPASS, BYP_OUT} state_t;
   localparam int LINES_D = 64;
   localparam int WORDS_D = 4;
   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction
   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction
   function automatic int tag_w(input int lines, input int words);
      return 30 - $clog2(lines) - $clog2(words);
   endfunction
endpackage

// File: rtl/icache_store.sv
// icache_store: tag/valid/data array with combinational lookup, word/tag writes and bulk invalidate
module icache_store
   import icache_pkg::*;
#(
   parameter int LINES = LINES_D,
   parameter int WORDS = WORDS_D,
   localparam int IB = idx_w(LINES),
   localparam int OB = off_w(WORDS),
   localparam int TW = tag_w(LINES, WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IB-1:0] rd_idx,
   input  logic [OB-1:0] rd_off,
   input  logic [TW-1:0] rd_tag,
   output logic          rd_hit,
   output logic [31:0]   rd_data,
   input  logic          we,
   input  logic [IB-1:0] w_idx,
   input  logic [OB-1:0] w_off,
   input  logic [31:0]   w_data,
   input  logic          tag_we,
   input  logic [TW-1:0] w_tag,
   input  logic          inv_all
);
   logic [LINES-1:0] valid;
   logic [TW-1:0]    tags [LINES];
   logic [31:0]      data [LINES][WORDS];
   assign rd_hit  = valid[rd_idx] && tags[rd_idx] == rd_tag;
   assign rd_data = data[rd_idx][rd_off];
   // invalidate wins over a same-edge tag write so a freshly filled line is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid <= '0;
      else begin
         if (tag_we) valid[w_idx] <= 1'b1;
         if (inv_all) valid <= '0;
      end
   end
   always_ff @(posedge clk) begin
      if (tag_we) tags[w_idx] <= w_tag;
      if (we) data[w_idx][w_off] <= w_data;
   end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with word-serial refill and uncached bypass
module inst_cache
   import icache_pkg::*;
#(
   parameter int LINES = LINES_D,
   parameter int WORDS = WORDS_D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        cache_en,
   input  logic        inv,
   output logic [31:0] inst,
   output logic        hit,
   output logic        freeze,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam int IB = idx_w(LINES);
   localparam int OB = off_w(WORDS);
   localparam int TW = tag_w(LINES, WORDS);
   state_t        state;
   logic [OB-1:0] cnt;
   logic [IB-1:0] ref_idx;
   logic [TW-1:0] ref_tag;
   logic [31:0]   byp;
   logic          inv_pend;
   logic [IB-1:0] idx;
   logic [OB-1:0] off;
   logic [TW-1:0] tag;
   logic          lk_hit, ack, last, fill_done, go_idle, inv_all;
   logic [31:0]   rd_data;
   assign off = pc[OB+1:2];
   assign idx = pc[OB+IB+1:OB+2];
   assign tag = pc[31:OB+IB+2];
   always_comb begin
      ack       = mem_ack && mem_req;
      last      = cnt == OB'(WORDS - 1);
      fill_done = state == REFILL && ack && last;
      go_idle   = fill_done || state == BYP_OUT;
      inv_all   = (state == IDLE && inv) || ((inv_pend || inv) && go_idle);
      hit       = cache_en && state == IDLE && lk_hit;
      freeze    = state == REFILL || state == BYPASS || (state == IDLE && !hit);
      inst      = state == BYP_OUT ? byp : rd_data;
   end
   icache_store #(.LINES(LINES), .WORDS(WORDS)) u_store (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (idx),
      .rd_off  (off),
      .rd_tag  (tag),
      .rd_hit  (lk_hit),
      .rd_data (rd_data),
      .we      (state == REFILL && ack),
      .w_idx   (ref_idx),
      .w_off   (cnt),
      .w_data  (mem_rdata),
      .tag_we  (fill_done),
      .w_tag   (ref_tag),
      .inv_all (inv_all)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ref_idx  <= '0;
         ref_tag  <= '0;
         byp      <= '0;
         inv_pend <= 1'b0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         inv_pend <= !go_idle && state != IDLE && (inv_pend || inv);
         case (state)
            IDLE:
               if (!cache_en) begin
                  state    <= BYPASS;
                  mem_req  <= 1'b1;
                  mem_addr <= pc & ~32'h3;
               end else if (!lk_hit) begin
                  state    <= REFILL;
                  cnt      <= '0;
                  ref_idx  <= idx;
                  ref_tag  <= tag;
                  mem_req  <= 1'b1;
                  mem_addr <= {tag, idx, {(OB + 2){1'b0}}};
               end
            REFILL:
               if (ack) begin
                  cnt      <= cnt + 1'b1;
                  mem_addr <= mem_addr + 32'd4;
                  if (last) begin
                     state   <= IDLE;
                     mem_req <= 1'b0;
                  end
               end
            BYPASS:
               if (ack) begin
                  byp     <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= BYP_OUT;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed self-checking bench for inst_cache with a latency-programmable memory
module tb_inst_cache;
   logic        clk = 0, rst = 1, cache_en = 1, inv = 0;
   logic [31:0] pc = 32'h40;
   logic [31:0] inst, mem_addr, mem_rdata;
   logic        hit, freeze, mem_req, mem_ack;
   int          checks = 0, errors = 0, lat = 0, wcnt = 0, frz;
   logic [31:0] reqs [$];
   logic        held = 0, moved = 0;
   logic [31:0] haddr = 0;
   always #5 clk = ~clk;
   inst_cache dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .cache_en  (cache_en),
      .inv       (inv),
      .inst      (inst),
      .hit       (hit),
      .freeze    (freeze),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      if (a >= 32'h40 && a <= 32'h4C) return 32'hA0 + (a - 32'h40) / 4;
      return ~a;
   endfunction
   assign mem_ack   = mem_req && wcnt >= lat;
   assign mem_rdata = mem_fn(mem_addr);
   always @(posedge clk or posedge rst) begin
      if (rst) wcnt <= 0;
      else wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
   end
   always @(posedge clk) begin
      if (mem_req && mem_ack) reqs.push_back(mem_addr);
      if (mem_req) begin
         if (held && mem_addr != haddr) moved <= 1;
         held  <= !mem_ack;
         haddr <= mem_addr;
      end else held <= 0;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic wait_free(output int n);
      n = 0;
      @(negedge clk);
      while (freeze && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("timeout", 32'(n < 100), 1);
   endtask
   task automatic fetch(input logic [31:0] a, output int n);
      @(posedge clk);
      #1 pc = a;
      reqs.delete();
      wait_free(n);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_hit", 32'(hit), 0);
      chk("rst_frz_c", 32'(freeze), 1);
      cache_en = 0;
      #1 chk("rst_frz_b", 32'(freeze), 1);
      cache_en = 1;
      @(posedge clk);
      #1 rst = 0;
      wait_free(frz);
      chk("cold_frz", frz, 5);
      chk("cold_inst", inst, 32'hA0);
      chk("cold_hit", 32'(hit), 1);
      chk("cold_n", reqs.size(), 4);
      for (int i = 0; i < 4 && i < reqs.size(); i++) chk("cold_addr", reqs[i], 32'h40 + 4 * i);
      for (int i = 1; i < 4; i++) begin
         fetch(32'h40 + 4 * i, frz);
         chk("seq_frz", frz, 0);
         chk("seq_inst", inst, 32'hA0 + i);
         chk("seq_hit", 32'(hit), 1);
         chk("seq_req", 32'(mem_req), 0);
      end
      chk("seq_n", reqs.size(), 0);
      fetch(32'h440, frz);
      chk("conf_frz", frz, 5);
      chk("conf_addr", reqs.size() > 0 ? reqs[0] : 32'hX, 32'h440);
      chk("conf_inst", inst, 32'hFFFFFBBF);
      fetch(32'h40, frz);
      chk("conf_back_frz", frz, 5);
      chk("conf_back_inst", inst, 32'hA0);
      lat = 3;
      fetch(32'h80, frz);
      chk("wait_frz", frz, 17);
      chk("wait_moved", 32'(moved), 0);
      chk("wait_n", reqs.size(), 4);
      chk("wait_inst", inst, 32'hFFFFFF7F);
      lat = 0;
      @(posedge clk);
      #1 cache_en = 0;
      pc = 32'h100;
      reqs.delete();
      wait_free(frz);
      chk("byp_frz", frz, 2);
      chk("byp_inst", inst, 32'hDEADBEEF);
      chk("byp_hit", 32'(hit), 0);
      chk("byp_n", reqs.size(), 1);
      chk("byp_addr", reqs.size() > 0 ? reqs[0] : 32'hX, 32'h100);
      @(posedge clk);
      #1 cache_en = 1;
      reqs.delete();
      wait_free(frz);
      chk("byp_nofill", frz, 5);
      chk("byp_fill_inst", inst, 32'hDEADBEEF);
      @(posedge clk);
      #1 pc = 32'h44;
      inv = 1;
      @(negedge clk);
      chk("inv_hit_same", 32'(hit), 1);
      chk("inv_inst_same", inst, 32'hA1);
      @(posedge clk);
      #1 inv = 0;
      wait_free(frz);
      chk("inv_idle_frz", frz, 5);
      @(posedge clk);
      #1 pc = 32'hC0;
      reqs.delete();
      @(posedge clk);
      #1 inv = 1;
      @(posedge clk);
      #1 inv = 0;
      frz = 0;
      @(negedge clk);
      while (mem_req && frz < 100) begin
         frz++;
         @(negedge clk);
      end
      chk("inv_ref_hit", 32'(hit), 0);
      chk("inv_ref_frz", 32'(freeze), 1);
      wait_free(frz);
      chk("inv_refill_frz", frz, 4);
      chk("inv_refill_hit", 32'(hit), 1);
      chk("inv_refill_inst", inst, 32'hFFFFFF3F);
      chk("inv_refill_n", reqs.size(), 8);
      @(posedge clk);
      #1 pc = 32'h200;
      @(posedge clk);
      #1 chk("rst_mid_req1", 32'(mem_req), 1);
      @(posedge clk);
      #1 rst = 1;
      #1 chk("rst_mid_req0", 32'(mem_req), 0);
      @(posedge clk);
      #1 rst = 0;
      pc = 32'h40;
      wait_free(frz);
      chk("rst_after_40", frz, 5);
      fetch(32'h200, frz);
      chk("rst_after_200", frz, 5);
      chk("rst_after_inst", inst, 32'hFFFFFDFF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
